memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, word address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, word width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 1, number of independent request channels.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from request acceptance to ready (legal range 1..15).
REQ-005 SHALL have parameter WRITE_ENABLE, default 1; 0 = read-only storage.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 mem_read_valid  input  NUM_CHANNELS  per-channel read request.
REQ-009 mem_read_address  input  ADDR_BITS x NUM_CHANNELS (unpacked)  read address per channel.
REQ-010 mem_read_ready  output  NUM_CHANNELS  per-channel read completion pulse.
REQ-011 mem_read_data  output  DATA_BITS x NUM_CHANNELS (unpacked)  read data, valid while ready high.
REQ-012 mem_write_valid  input  NUM_CHANNELS  per-channel write request.
REQ-013 mem_write_address  input  ADDR_BITS x NUM_CHANNELS  write address.
REQ-014 mem_write_data  input  DATA_BITS x NUM_CHANNELS  write data.
REQ-015 mem_write_ready  output  NUM_CHANNELS  per-channel write completion pulse.
REQ-016 load_en / load_address / load_data  input  1 / ADDR_BITS / DATA_BITS  backdoor preload port.

Function
REQ-017 SHALL hold 2^ADDR_BITS words of DATA_BITS storage.
REQ-018 Each channel SHALL run an independent FSM: IDLE, READ_BUSY, WRITE_BUSY, RESPOND, RELEASE.
REQ-019 IDLE: valid sampled high at edge E0 -> latch address (and write data), load counter, go READ_BUSY/WRITE_BUSY; read has priority if both valids high; the write stays pending.
REQ-020 BUSY: counter decrements each cycle; ready SHALL assert for exactly the cycle following edge E0+LATENCY, then the channel enters RESPOND.
REQ-021 Read data SHALL be taken from storage at the edge ready asserts and held on mem_read_data[i] until the next accepted read on that channel.
REQ-022 A write SHALL commit to storage at the same edge mem_write_ready[i] asserts; if WRITE_ENABLE=0 it is acknowledged identically but storage is unchanged.
REQ-023 RESPOND: ready SHALL deassert at the next edge regardless of valid; the channel enters RELEASE.
REQ-024 RELEASE: wait until the corresponding valid is sampled low, then return to IDLE; a valid held high SHALL NOT start a new access (one access per valid assertion).
REQ-025 Valid dropping while BUSY = abort: return to IDLE next edge; no ready pulse; no write commit.
REQ-026 Same-edge write collisions to one address: highest-index channel wins; load_en beats all channel writes.
REQ-027 A read and a write to the same address completing at the same edge SHALL return the pre-write value.
REQ-028 load_en SHALL write load_data to load_address at that edge in any state; it has no handshake.
REQ-029 Channels SHALL NOT block one another; all may complete in the same cycle.

Reset
REQ-030 reset SHALL drive all FSMs to IDLE, clear counters, mem_read_ready=0, mem_write_ready=0, mem_read_data=0 within one edge.
REQ-031 reset SHALL NOT clear storage contents.
REQ-032 reset during BUSY SHALL discard the access with no write commit and no ready.

Verification
REQ-033 LATENCY=2: load 0x10=0xBEEF; read valid ch0 addr 0x10 sampled at E0 -> read_ready high for one cycle after E0+2, data 0xBEEF.
REQ-034 write ch0 addr 0x22 data 0x1234, valid held 4 cycles -> exactly one write_ready pulse; a subsequent read of 0x22 returns 0x1234.
REQ-035 NUM_CHANNELS=2: ch0 and ch1 both write addr 0x05 (0xAAAA, 0x5555) on the same edge -> both get ready; a later read returns 0x5555.
REQ-036 Read valid dropped one cycle after acceptance -> no ready pulse; channel accepts a new request two cycles later.
REQ-037 WRITE_ENABLE=0: write 0x0001 to preloaded addr 0x30=0x7777 -> ready pulse; read returns 0x7777.
REQ-038 reset asserted while ch0 is WRITE_BUSY to 0x40 (preloaded 0x0F0F) -> no ready; after release a read of 0x40 returns 0x0F0F.

Source files
------------

// File: rtl/memory_responder.sv
// memory_responder: multi-channel memory model with per-channel read/write
// handshakes, a fixed access latency and a backdoor preload port.
// Each channel runs its own FSM. Read data is captured and writes commit at
// the edge that raises the ready pulse. One access is made per valid assertion.
module memory_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 1,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    input  logic                    load_en,
    input  logic [ADDR_BITS-1:0]    load_address,
    input  logic [DATA_BITS-1:0]    load_data
);

    localparam int       CNT_W     = 4;
    localparam bit       WRITES_ON = (WRITE_ENABLE != 0);
    localparam int       DEPTH     = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        READ_BUSY,
        WRITE_BUSY,
        RESPOND,
        RELEASE
    } state_t;

    // Storage is deliberately never reset so preloaded contents survive reset.
    logic [DATA_BITS-1:0] mem [DEPTH];

    // Per-channel commit requests gathered for the single storage write port.
    logic                 commit_en   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] commit_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0] commit_data [NUM_CHANNELS];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        state_t               state, state_next;
        logic [CNT_W-1:0]     cnt, cnt_next;
        logic                 op_write, op_write_next;
        logic [ADDR_BITS-1:0] addr_q, addr_next;
        logic [DATA_BITS-1:0] wdata_q, wdata_next;
        logic                 read_done, write_done;
        logic                 read_ready_q, write_ready_q;
        logic [DATA_BITS-1:0] read_data_q;

        // Next-state logic: accept, count down latency, abort on valid drop, release.
        always_comb begin
            state_next    = state;
            cnt_next      = cnt;
            op_write_next = op_write;
            addr_next     = addr_q;
            wdata_next    = wdata_q;
            read_done     = 1'b0;
            write_done    = 1'b0;
            case (state)
                IDLE: begin
                    // Read wins when both valids are high; the write waits its turn.
                    if (mem_read_valid[i]) begin
                        state_next    = READ_BUSY;
                        cnt_next      = CNT_W'(LATENCY - 1);
                        op_write_next = 1'b0;
                        addr_next     = mem_read_address[i];
                    end else if (mem_write_valid[i]) begin
                        state_next    = WRITE_BUSY;
                        cnt_next      = CNT_W'(LATENCY - 1);
                        op_write_next = 1'b1;
                        addr_next     = mem_write_address[i];
                        wdata_next    = mem_write_data[i];
                    end
                end
                READ_BUSY: begin
                    if (!mem_read_valid[i]) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == '0) begin
                        state_next = RESPOND;
                        read_done  = 1'b1;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                WRITE_BUSY: begin
                    if (!mem_write_valid[i]) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == '0) begin
                        state_next = RESPOND;
                        write_done = 1'b1;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                RESPOND: begin
                    state_next = RELEASE;
                end
                RELEASE: begin
                    // Only the valid of the access just served can release the channel.
                    if (op_write ? !mem_write_valid[i] : !mem_read_valid[i]) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Control registers: FSM state, latency counter, ready pulses, read data.
        always_ff @(posedge clk) begin
            if (reset) begin
                state         <= IDLE;
                cnt           <= '0;
                read_ready_q  <= 1'b0;
                write_ready_q <= 1'b0;
                read_data_q   <= '0;
            end else begin
                state         <= state_next;
                cnt           <= cnt_next;
                read_ready_q  <= read_done;
                write_ready_q <= write_done;
                if (read_done) begin
                    read_data_q <= mem[addr_q];
                end
            end
        end

        // Request capture: address, write data and access type latched on acceptance.
        always_ff @(posedge clk) begin
            op_write <= op_write_next;
            addr_q   <= addr_next;
            wdata_q  <= wdata_next;
        end

        assign commit_en[i]       = write_done & ~reset;
        assign commit_addr[i]     = addr_q;
        assign commit_data[i]     = wdata_q;
        assign mem_read_ready[i]  = read_ready_q;
        assign mem_write_ready[i] = write_ready_q;
        assign mem_read_data[i]   = read_data_q;
    end

    // Storage write port: later channels override earlier ones, preload overrides all.
    always_ff @(posedge clk) begin
        if (WRITES_ON) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (commit_en[c]) begin
                    mem[commit_addr[c]] <= commit_data[c];
                end
            end
        end
        if (load_en) begin
            mem[load_address] <= load_data;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed bench for memory_responder, using a two-channel
// writable instance and a single-channel read-only instance.
module tb_memory_responder;

    localparam int AB = 8;
    localparam int DB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    rd_valid, rd_ready, wr_valid, wr_ready;
    logic [AB-1:0] rd_addr [2];
    logic [AB-1:0] wr_addr [2];
    logic [DB-1:0] rd_data [2];
    logic [DB-1:0] wr_data [2];
    logic          load_en;
    logic [AB-1:0] load_address;
    logic [DB-1:0] load_data;

    logic [0:0]    ro_rd_valid, ro_rd_ready, ro_wr_valid, ro_wr_ready;
    logic [AB-1:0] ro_rd_addr [1];
    logic [AB-1:0] ro_wr_addr [1];
    logic [DB-1:0] ro_rd_data [1];
    logic [DB-1:0] ro_wr_data [1];

    int checks   = 0;
    int failures = 0;

    memory_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(2),
                       .LATENCY(2), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rd_valid), .mem_read_address(rd_addr),
        .mem_read_ready(rd_ready), .mem_read_data(rd_data),
        .mem_write_valid(wr_valid), .mem_write_address(wr_addr),
        .mem_write_data(wr_data), .mem_write_ready(wr_ready),
        .load_en(load_en), .load_address(load_address), .load_data(load_data)
    );

    memory_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(1),
                       .LATENCY(2), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .mem_read_valid(ro_rd_valid), .mem_read_address(ro_rd_addr),
        .mem_read_ready(ro_rd_ready), .mem_read_data(ro_rd_data),
        .mem_write_valid(ro_wr_valid), .mem_write_address(ro_wr_addr),
        .mem_write_data(ro_wr_data), .mem_write_ready(ro_wr_ready),
        .load_en(load_en), .load_address(load_address), .load_data(load_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AB-1:0] a, input logic [DB-1:0] d);
        load_en = 1'b1; load_address = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Full read on the writable instance; lat is the tick on which ready was seen (0 = none).
    task automatic do_read(input int ch, input logic [AB-1:0] a,
                           output logic [DB-1:0] d, output int lat);
        rd_addr[ch] = a; rd_valid[ch] = 1'b1; lat = 0; d = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rd_ready[ch]) begin lat = k; d = rd_data[ch]; break; end
        end
        rd_valid[ch] = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DB-1:0] d;
        int lat, pulses, at, at0, at1;
        logic both;

        reset = 1'b1; rd_valid = '0; wr_valid = '0; load_en = 1'b0;
        load_address = '0; load_data = '0;
        rd_addr[0] = '0; rd_addr[1] = '0; wr_addr[0] = '0; wr_addr[1] = '0;
        wr_data[0] = '0; wr_data[1] = '0;
        ro_rd_valid = '0; ro_wr_valid = '0; ro_rd_addr[0] = '0;
        ro_wr_addr[0] = '0; ro_wr_data[0] = '0;
        tick(); tick();
        check("reset_rd_ready", 32'(rd_ready), 0);
        check("reset_wr_ready", 32'(wr_ready), 0);
        check("reset_rd_data0", 32'(rd_data[0]), 0);
        check("reset_rd_data1", 32'(rd_data[1]), 0);
        check("reset_ro_ready", 32'({ro_rd_ready, ro_wr_ready}), 0);
        reset = 1'b0;
        tick();

        // Basic read with valid held: single pulse two cycles after acceptance.
        load(8'h10, 16'hBEEF);
        rd_addr[0] = 8'h10; rd_valid[0] = 1'b1; pulses = 0; at = 0; d = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rd_ready[0]) begin
                pulses++;
                if (at == 0) begin at = k; d = rd_data[0]; end
            end
        end
        check("read_pulses", 32'(pulses), 1);
        check("read_latency", 32'(at), 3);
        check("read_data", 32'(d), 'hBEEF);
        rd_valid[0] = 1'b0; tick(); tick();

        // Write with valid held four sampled edges: one pulse, data committed.
        wr_addr[0] = 8'h22; wr_data[0] = 16'h1234; wr_valid[0] = 1'b1;
        pulses = 0; at = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) wr_valid[0] = 1'b0;
            if (wr_ready[0]) begin pulses++; if (at == 0) at = k; end
        end
        check("write_pulses", 32'(pulses), 1);
        check("write_latency", 32'(at), 3);
        do_read(0, 8'h22, d, lat);
        check("write_readback", 32'(d), 'h1234);
        check("write_readback_lat", 32'(lat), 3);

        // Read aborted one cycle after acceptance, new read accepted two cycles later.
        rd_addr[0] = 8'h10; rd_valid[0] = 1'b1;
        tick();
        rd_valid[0] = 1'b0;
        tick();
        check("abort_no_ready_e1", 32'(rd_ready[0]), 0);
        rd_addr[0] = 8'h22; rd_valid[0] = 1'b1;
        tick();
        check("abort_no_ready_e2", 32'(rd_ready[0]), 0);
        tick();
        check("abort_no_ready_e3", 32'(rd_ready[0]), 0);
        tick();
        check("reaccept_ready", 32'(rd_ready[0]), 1);
        check("reaccept_data", 32'(rd_data[0]), 'h1234);
        rd_valid[0] = 1'b0; tick(); tick();

        // Aborted write: no pulse and no commit.
        wr_addr[0] = 8'h22; wr_data[0] = 16'hDEAD; wr_valid[0] = 1'b1;
        tick();
        wr_valid[0] = 1'b0; pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (wr_ready[0]) pulses++;
        end
        check("wabort_pulses", 32'(pulses), 0);
        do_read(0, 8'h22, d, lat);
        check("wabort_data", 32'(d), 'h1234);

        // Same-edge writes to one address: both ready, higher channel wins.
        wr_addr[0] = 8'h05; wr_data[0] = 16'hAAAA;
        wr_addr[1] = 8'h05; wr_data[1] = 16'h5555;
        wr_valid = 2'b11; at0 = 0; at1 = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (wr_ready[0] && at0 == 0) at0 = k;
            if (wr_ready[1] && at1 == 0) at1 = k;
            if (at0 != 0 && at1 != 0) break;
        end
        wr_valid = 2'b00; tick(); tick();
        check("collide_ready_ch0", 32'(at0), 3);
        check("collide_ready_ch1", 32'(at1), 3);
        do_read(0, 8'h05, d, lat);
        check("collide_data", 32'(d), 'h5555);

        // Read and write to one address completing together: read sees old value.
        load(8'h60, 16'h1111);
        rd_addr[0] = 8'h60; rd_valid[0] = 1'b1;
        wr_addr[1] = 8'h60; wr_data[1] = 16'h2222; wr_valid[1] = 1'b1;
        d = '0; both = 1'b0; at = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rd_ready[0]) begin at = k; d = rd_data[0]; both = wr_ready[1]; break; end
        end
        rd_valid[0] = 1'b0; wr_valid[1] = 1'b0; tick(); tick();
        check("rw_same_edge_lat", 32'(at), 3);
        check("rw_same_edge_wready", 32'(both), 1);
        check("rw_same_edge_old", 32'(d), 'h1111);
        do_read(1, 8'h60, d, lat);
        check("rw_same_edge_new", 32'(d), 'h2222);

        // Preload landing on a channel write's commit edge wins.
        wr_addr[0] = 8'h70; wr_data[0] = 16'hAAAA; wr_valid[0] = 1'b1;
        tick(); tick();
        load_en = 1'b1; load_address = 8'h70; load_data = 16'hCCCC;
        tick();
        load_en = 1'b0;
        check("load_win_wready", 32'(wr_ready[0]), 1);
        wr_valid[0] = 1'b0; tick(); tick();
        do_read(0, 8'h70, d, lat);
        check("load_win_data", 32'(d), 'hCCCC);

        // Read and write valid together: read first, write served after release.
        rd_addr[0] = 8'h22; rd_valid[0] = 1'b1;
        wr_addr[0] = 8'h50; wr_data[0] = 16'hABCD; wr_valid[0] = 1'b1;
        at = 0; pulses = 0; d = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (wr_ready[0]) pulses++;
            if (rd_ready[0]) begin at = k; d = rd_data[0]; break; end
        end
        check("prio_read_lat", 32'(at), 3);
        check("prio_read_data", 32'(d), 'h1234);
        check("prio_no_early_write", 32'(pulses), 0);
        rd_valid[0] = 1'b0; at = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (wr_ready[0]) begin at = k; break; end
        end
        check("prio_write_lat", 32'(at), 5);
        wr_valid[0] = 1'b0; tick(); tick();
        do_read(0, 8'h50, d, lat);
        check("prio_write_data", 32'(d), 'hABCD);

        // Reset while write busy: access discarded, storage preserved, read data cleared.
        load(8'h40, 16'h0F0F);
        wr_addr[0] = 8'h40; wr_data[0] = 16'h9999; wr_valid[0] = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_busy_no_ready", 32'(wr_ready[0]), 0);
        check("rst_busy_rd_data", 32'(rd_data[0]), 0);
        reset = 1'b0; wr_valid[0] = 1'b0;
        tick();
        check("rst_busy_no_ready2", 32'(wr_ready[0]), 0);
        tick();
        do_read(0, 8'h40, d, lat);
        check("rst_busy_data", 32'(d), 'h0F0F);

        // Read-only instance: write acknowledged normally, storage unchanged.
        load(8'h30, 16'h7777);
        ro_wr_addr[0] = 8'h30; ro_wr_data[0] = 16'h0001; ro_wr_valid = 1'b1; at = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ro_wr_ready[0]) begin at = k; break; end
        end
        ro_wr_valid = 1'b0; tick(); tick();
        check("ro_write_lat", 32'(at), 3);
        ro_rd_addr[0] = 8'h30; ro_rd_valid = 1'b1; at = 0; d = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ro_rd_ready[0]) begin at = k; d = ro_rd_data[0]; break; end
        end
        ro_rd_valid = 1'b0; tick(); tick();
        check("ro_read_lat", 32'(at), 3);
        check("ro_read_data", 32'(d), 'h7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
